term_ctrl: RTL and testbench

- Byte-stream front end that initiates service calls on the bios block: the requester side of the bios start/svc/a/b/running handshake.
- Accepts received serial bytes, buffers them in a small FIFO and decodes them.
- Issues one bios service per action and waits for completion before issuing the next.
- Sits between the UART receiver and bios in the serial terminal top level.

---
 rtl/term_ctrl.sv | 165 ++++++++++++++++
 tb/tb_term_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_ctrl.sv
// term_ctrl: serial byte front end that buffers received bytes and issues bios service calls
// Ports: i_clk/i_rst (sync, active high); i_rx_data/i_rx_valid byte strobe from the UART;
// o_bios_start/o_bios_svc/o_bios_a/o_bios_b/i_bios_running bios requester handshake;
// o_busy, o_overflow (sticky drop flag), o_fifo_level (input FIFO occupancy).
// Optional ANSI_CUP_EN macro compiles in the ESC '[' cursor/clear sequence parser.
module term_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_bios_start,
  output logic [2:0]                    o_bios_svc,
  output logic [7:0]                    o_bios_a,
  output logic [7:0]                    o_bios_b,
  input  logic                          i_bios_running,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, POP, DECODE, ISSUE, GUARD, WAIT, CHAIN} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [7:0] byte_r, d_a, d_b;
  logic [2:0] d_svc;
  logic call, d_chain, chain, push, pop;
  assign pop = state == POP;
  // a pop in the same cycle frees a slot, so a write on a full FIFO is still taken
  assign push = i_rx_valid && (level != (AW+1)'(FIFO_DEPTH) || pop);
  assign o_bios_start = state == ISSUE;
  assign o_busy = level != '0 || state != IDLE;
  assign o_fifo_level = level;
`ifdef ANSI_CUP_EN
  typedef enum logic [1:0] {E_NONE, E_ESC, E_CSI} esc_t;
  esc_t esc, esc_n;
  logic [7:0] row, col, row_n, col_n, acc_sat;
  logic [11:0] acc_x;
  logic fld, fld_n;
  assign acc_x = 12'(fld ? col : row) * 12'd10 + 12'(byte_r - 8'h30);
  assign acc_sat = acc_x > 12'd255 ? 8'hff : acc_x[7:0];
  // a zero field means "missing" and behaves as 1
  function automatic logic [7:0] clamp(input logic [7:0] v, input int lim);
    return v == 8'd0 ? 8'd0 : (int'(v) > lim ? 8'(lim - 1) : v - 8'd1);
  endfunction
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      esc <= E_NONE;
      row <= '0;
      col <= '0;
      fld <= 1'b0;
    end else if (state == DECODE) begin
      esc <= esc_n;
      row <= row_n;
      col <= col_n;
      fld <= fld_n;
    end
  end
`endif
  always_comb begin
    call = 1'b0;
    d_svc = 3'd4;
    d_a = byte_r;
    d_b = 8'd1;
    d_chain = 1'b0;
`ifdef ANSI_CUP_EN
    esc_n = esc;
    row_n = row;
    col_n = col;
    fld_n = fld;
    if (byte_r == 8'h1b) begin
      esc_n = E_ESC;
      row_n = '0;
      col_n = '0;
      fld_n = 1'b0;
    end else if (esc == E_ESC) begin
      esc_n = byte_r == 8'h5b ? E_CSI : E_NONE;
    end else if (esc == E_CSI) begin
      esc_n = E_NONE;
      if (byte_r >= 8'h30 && byte_r <= 8'h39) begin
        esc_n = E_CSI;
        row_n = fld ? row : acc_sat;
        col_n = fld ? acc_sat : col;
      end else if (byte_r == 8'h3b && !fld) begin
        esc_n = E_CSI;
        fld_n = 1'b1;
      end else if (byte_r == 8'h48 || byte_r == 8'h66) begin
        call = 1'b1;
        d_svc = 3'd2;
        d_a = clamp(col, COLS);
        d_b = clamp(row, ROWS);
      end else if (byte_r == 8'h4a && !fld && row == 8'd2) begin
        call = 1'b1;
        d_svc = 3'd0;
        d_a = '0;
        d_b = '0;
        d_chain = 1'b1;
      end
    end else
`endif
    if (byte_r == 8'h0c) begin
      call = 1'b1;
      d_svc = 3'd0;
      d_a = '0;
      d_b = '0;
      d_chain = 1'b1;
    end else
      call = byte_r != 8'h00;
  end
  // WAIT goes straight to POP when more bytes are queued, giving 5 cycles per byte
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = level != '0 ? POP : IDLE;
      POP:     state_n = DECODE;
      DECODE:  state_n = call ? ISSUE : IDLE;
      ISSUE:   state_n = GUARD;
      GUARD:   state_n = WAIT;
      WAIT:    state_n = i_bios_running ? WAIT : chain ? CHAIN : level != '0 ? POP : IDLE;
      CHAIN:   state_n = ISSUE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_rx_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      byte_r <= '0;
      chain <= 1'b0;
      o_bios_svc <= '0;
      o_bios_a <= '0;
      o_bios_b <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      o_overflow <= o_overflow | (i_rx_valid & ~push);
      if (pop) byte_r <= mem[rd_ptr];
      if (state == DECODE && call) begin
        o_bios_svc <= d_svc;
        o_bios_a <= d_a;
        o_bios_b <= d_b;
        chain <= d_chain;
      end
      if (state == CHAIN) begin
        o_bios_svc <= 3'd2;
        o_bios_a <= '0;
        o_bios_b <= '0;
        chain <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_term_ctrl.sv
// tb_term_ctrl: randomized and directed bench for term_ctrl against a byte-level decode model
module tb_term_ctrl;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  logic clk, rst, rx_valid, bios_start, bios_running, busy, overflow;
  logic [7:0] rx_data, bios_a, bios_b;
  logic [2:0] bios_svc;
  logic [4:0] fifo_level;
  int checks = 0;
  int failures = 0;
  int lat = 3;
  int cnt = 0;
  bit force_run = 0;
  bit in_call = 0;
  bit m_esc = 0;
  bit drop;
  logic [18:0] held;
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  logic [7:0] m_seq[$];
  logic [7:0] alpha [14];
  term_ctrl #(.FIFO_DEPTH(16), .COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_bios_start(bios_start), .o_bios_svc(bios_svc), .o_bios_a(bios_a), .o_bios_b(bios_b),
    .i_bios_running(bios_running), .o_busy(busy), .o_overflow(overflow), .o_fifo_level(fifo_level)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int clampm(int v, int lim);
    int x = v < 1 ? 1 : v;
    return (x > lim ? lim : x) - 1;
  endfunction
  // reference decoder: whole escape sequences are interpreted once their final byte arrives
  task automatic model(input logic [7:0] b);
`ifdef ANSI_CUP_EN
    int r, c, n, semis;
    if (b == 8'h1b) begin
      m_esc = 1;
      m_seq.delete();
      return;
    end
    if (m_esc) begin
      m_seq.push_back(b);
      if (m_seq[0] != 8'h5b) begin
        m_esc = 0;
        return;
      end
      if (m_seq.size() == 1) return;
      semis = 0;
      foreach (m_seq[i]) if (m_seq[i] == 8'h3b) semis++;
      if ((b >= 8'h30 && b <= 8'h39) || (b == 8'h3b && semis == 1)) return;
      m_esc = 0;
      r = 0;
      c = 0;
      n = 0;
      for (int i = 1; i < m_seq.size() - 1; i++) begin
        if (m_seq[i] == 8'h3b) n = 1;
        else if (n == 0) r = r * 10 + int'(m_seq[i]) - 48;
        else c = c * 10 + int'(m_seq[i]) - 48;
        if (r > 255) r = 255;
        if (c > 255) c = 255;
      end
      if (b == 8'h48 || b == 8'h66) exp_q.push_back({3'd2, 8'(clampm(c, COLS)), 8'(clampm(r, ROWS))});
      else if (b == 8'h4a && semis == 0 && r == 2) begin
        exp_q.push_back(19'h0);
        exp_q.push_back({3'd2, 16'h0});
      end
      return;
    end
`endif
    if (b == 8'h0c) begin
      exp_q.push_back(19'h0);
      exp_q.push_back({3'd2, 16'h0});
    end else if (b != 8'h00)
      exp_q.push_back({3'd4, b, 8'd1});
  endtask
  task automatic put(input logic [7:0] b, input bit modeled = 1);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1;
    if (modeled) model(b);
  endtask
  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask
  task automatic idle_rx();
    @(negedge clk);
    rx_valid = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !bios_running) return;
    end
    chk("idle_timeout", 1, 0);
  endtask
  task automatic wait_calls(input int n);
    for (int i = 0; i < 300; i++) begin
      if (obs_q.size() >= n) return;
      @(negedge clk);
    end
    chk("start_timeout", obs_q.size(), n);
  endtask
  task automatic cmp_calls(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask
  // bios stand-in: records each call, runs for lat cycles (random when lat<0)
  initial begin
    bios_running = 0;
    forever begin
      @(negedge clk);
      if (bios_start) begin
        chk("start_while_busy", in_call, 0);
        obs_q.push_back({bios_svc, bios_a, bios_b});
        held = {bios_svc, bios_a, bios_b};
        in_call = 1;
        cnt = lat < 0 ? int'($urandom_range(0, 4)) : lat;
      end else begin
        if (in_call && bios_running && busy && !rst) chk("hold", {bios_svc, bios_a, bios_b}, held);
        if (cnt > 0) cnt--;
      end
      bios_running = cnt > 0 || force_run;
      if (!bios_running) in_call = 0;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    alpha = '{8'h1b, 8'h5b, 8'h31, 8'h32, 8'h35, 8'h39, 8'h3b, 8'h48, 8'h66, 8'h4a, 8'h51, 8'h41, 8'h0c, 8'h00};
    rst = 1;
    rx_valid = 0;
    rx_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", bios_start, 0);
    chk("rst_svcab", {bios_svc, bios_a, bios_b}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", fifo_level, 0);
    rst = 0;
    put(8'h41);
    put(8'h42);
    idle_rx();
    wait_idle();
    if (obs_q.size() == 2) begin
      chk("ab_first", obs_q[0], {3'd4, 8'h41, 8'h01});
      chk("ab_second", obs_q[1], {3'd4, 8'h42, 8'h01});
    end
    cmp_calls("ab");
    put(8'h0c);
    idle_rx();
    drop = 0;
    for (int i = 0; i < 200 && obs_q.size() < 2; i++) begin
      @(negedge clk);
      if (!busy) drop = 1;
    end
    chk("ff_busy_drop", drop, 0);
    wait_idle();
    if (obs_q.size() == 2) begin
      chk("ff_clear", obs_q[0], 19'h0);
      chk("ff_home", obs_q[1], {3'd2, 16'h0});
    end
    cmp_calls("ff");
    force_run = 1;
    put(8'h50);
    idle_rx();
    wait_calls(1);
    for (int i = 0; i < 20; i++) put(8'h60 + 8'(i), i < 16);
    idle_rx();
    chk("ovf_level", fifo_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_busy", busy, 1);
    force_run = 0;
    wait_idle();
    chk("ovf_calls", obs_q.size(), 17);
    cmp_calls("ovf_order");
    chk("ovf_sticky", overflow, 1);
`ifdef ANSI_CUP_EN
    put(8'h1b);
    put_str("[5;12H");
    idle_rx();
    wait_idle();
    if (obs_q.size() == 1) chk("cup_5_12", obs_q[0], {3'd2, 8'd11, 8'd4});
    cmp_calls("cup1");
    put(8'h1b);
    put_str("[99;200H");
    idle_rx();
    wait_idle();
    if (obs_q.size() == 1) chk("cup_clamp", obs_q[0], {3'd2, 8'd79, 8'd29});
    cmp_calls("cup2");
    put(8'h1b);
    put_str("[2J");
    idle_rx();
    wait_idle();
    if (obs_q.size() == 2) chk("ed_home", obs_q[1], {3'd2, 16'h0});
    cmp_calls("ed");
    put(8'h1b);
    put_str("[5Q");
    idle_rx();
    wait_idle();
    chk("bad_final", obs_q.size(), 0);
    cmp_calls("bad");
`else
    put(8'h1b);
    idle_rx();
    wait_idle();
    if (obs_q.size() == 1) chk("esc_plain", obs_q[0], {3'd4, 8'h1b, 8'h01});
    cmp_calls("esc");
`endif
    force_run = 1;
    put(8'h61);
    idle_rx();
    wait_calls(1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_start", bios_start, 0);
    chk("mid_rst_svcab", {bios_svc, bios_a, bios_b}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_level", fifo_level, 0);
    force_run = 0;
    repeat (10) @(negedge clk);
    chk("no_reissue", obs_q.size(), 1);
    cmp_calls("mid_rst");
    put(8'h78);
    put(8'h79);
    idle_rx();
    wait_idle();
    cmp_calls("post_rst");
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      int len = $urandom_range(1, 16);
      for (int j = 0; j < len; j++) begin
        int idx = $urandom_range(0, 15);
        put(idx < 14 ? alpha[idx] : 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 1) == 1) idle_rx();
      end
      idle_rx();
      wait_idle();
    end
    cmp_calls("rand");
    chk("rand_no_ovf", overflow, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
